// File: rtl/fmap_stream_tx_if.sv
// Host/stream bundle for fmap_stream_tx: frame-RAM write port, start/busy control and outgoing pixel stream.
// stream_bank exists only when FMAP_PINGPONG_EN is defined.
interface fmap_stream_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  start;
  logic                  busy;
  logic                  data_valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;
`ifdef FMAP_PINGPONG_EN
  logic                  stream_bank;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, start,
`ifdef FMAP_PINGPONG_EN
    input  stream_bank,
`endif
    input  busy, data_valid_out, data_out, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
`ifdef FMAP_PINGPONG_EN
    output stream_bank,
`endif
    output busy, data_valid_out, data_out, frame_done
  );
endinterface

// File: rtl/fmap_stream_tx.sv
// Feature-map stream transmitter: frame RAM replayed in raster order, followed by zero flush beats.
// Optional FMAP_PINGPONG_EN: two RAM banks so the next frame can be loaded while one streams.
module fmap_stream_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56,
  parameter int FLUSH_LEN  = IMG_WIDTH + 1,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              resetn,
  fmap_stream_tx_if.slave   bus
);

  localparam int PIX_COUNT = IMG_WIDTH * IMG_HEIGHT;
  localparam int FCW       = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST   = ADDR_WIDTH'(PIX_COUNT - 1);
  localparam logic [ADDR_WIDTH:0]   PIX_LIMIT  = (ADDR_WIDTH + 1)'(PIX_COUNT);
  localparam logic [FCW-1:0]        FLUSH_LAST = FCW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pix_cnt, pix_next;
  logic [FCW-1:0]        flush_cnt, flush_next;
  logic                  busy, busy_next;
  logic                  valid_q, valid_next;
  logic                  done_q, done_next;
  logic                  rd_en;
  logic                  accept;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] data_q;

  // busy outlives the FSM by one cycle so the frame_done cycle still blocks start and writes
  assign accept = (state == IDLE) && !busy && bus.start;
  assign wr_ok  = bus.wr_en && ({1'b0, bus.wr_addr} < PIX_LIMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      pix_cnt   <= pix_next;
      flush_cnt <= flush_next;
      busy      <= busy_next;
      valid_q   <= valid_next;
      done_q    <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    pix_next   = pix_cnt;
    flush_next = flush_cnt;
    busy_next  = busy;
    valid_next = 1'b0;
    done_next  = 1'b0;
    rd_en      = 1'b0;
    if (done_q) busy_next = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = STREAM;
          pix_next   = '0;
          busy_next  = 1'b1;
        end
      end
      STREAM: begin
        rd_en      = 1'b1;
        valid_next = 1'b1;
        pix_next   = pix_cnt + 1'b1;
        if (pix_cnt == PIX_LAST) begin
          pix_next = '0;
          if (FLUSH_LEN > 0) begin
            state_next = FLUSH;
            flush_next = '0;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      FLUSH: begin
        valid_next = 1'b1;
        flush_next = flush_cnt + 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          flush_next = '0;
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FMAP_PINGPONG_EN
  logic [DATA_WIDTH-1:0] mem [0:1][0:PIX_COUNT-1];
  logic                  stream_bank;

  // The fill bank is always the one not streaming; a start hands it over to the reader
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stream_bank <= 1'b0;
    else if (accept) stream_bank <= ~stream_bank;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[~stream_bank][bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) data_q <= '0;
    else if (rd_en) data_q <= mem[stream_bank][pix_cnt];
    else data_q <= '0;
  end

  assign bus.stream_bank = stream_bank;
`else
  logic [DATA_WIDTH-1:0] mem [0:PIX_COUNT-1];

  always_ff @(posedge clk) begin
    if (wr_ok && !busy) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) data_q <= '0;
    else if (rd_en) data_q <= mem[pix_cnt];
    else data_q <= '0;
  end
`endif

  assign bus.busy           = busy;
  assign bus.data_valid_out = valid_q;
  assign bus.data_out       = data_q;
  assign bus.frame_done     = done_q;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Bench for fmap_stream_tx: two 4x4 instances (FLUSH_LEN 5 and 0) driven in lockstep with random frames,
// compared beat-by-beat against a frame-snapshot model of the expected stream.
module tb_fmap_stream_tx;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int N   = W * H;
  localparam int F_A = 5;
  localparam int F_B = 0;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          start = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [2][N];
  logic [31:0] snap [N];
  int          model_stream = 0;

  fmap_stream_tx_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus_a ();
  fmap_stream_tx_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.wr_en = wr_en;   assign bus_b.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data;
  assign bus_a.start = start;   assign bus_b.start = start;

  fmap_stream_tx #(.DATA_WIDTH(32), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FLUSH_LEN(F_A), .ADDR_WIDTH(AW))
    dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  fmap_stream_tx #(.DATA_WIDTH(32), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FLUSH_LEN(F_B), .ADDR_WIDTH(AW))
    dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] toFloat(input int i);
    int e;
    if (i == 0) return 32'h0;
    e = 0;
    for (int k = 0; k < 24; k++) if ((i >> k) != 0) e = k;
    return (32'(127 + e) << 23) | (32'(i - (1 << e)) << (23 - e));
  endfunction

  // Writes land in the fill bank (pingpong) or in the single bank only while idle
  task automatic modelWrite(input int addr, input logic [31:0] d, input bit busy_now);
`ifdef FMAP_PINGPONG_EN
    model_mem[1 - model_stream][addr] = d;
`else
    if (!busy_now) model_mem[0][addr] = d;
`endif
  endtask

  task automatic modelStart();
`ifdef FMAP_PINGPONG_EN
    model_stream = 1 - model_stream;
`endif
    for (int i = 0; i < N; i++) snap[i] = model_mem[model_stream][i];
  endtask

  task automatic writeWord(input int addr, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = d;
    modelWrite(addr, d, 1'b0);
    tick();
    wr_en = 1'b0;
  endtask

  // t counts edges since the start edge: beat t-1 is on the bus, busy spans t = 0..N+F
  task automatic checkDut(input string name, input int f, input int t, input logic busy,
                          input logic valid, input logic [31:0] data, input logic done,
                          input logic bank);
    int          b;
    logic        ev;
    logic [31:0] ed;
    b  = t - 1;
    ev = (b >= 0) && (b < N + f);
    ed = (ev && b < N) ? snap[b] : 32'h0;
    checkOutput($sformatf("%s_t%0d_busy", name, t), 32'(busy), 32'(t <= N + f));
    checkOutput($sformatf("%s_t%0d_valid", name, t), 32'(valid), 32'(ev));
    checkOutput($sformatf("%s_t%0d_data", name, t), data, ed);
    checkOutput($sformatf("%s_t%0d_done", name, t), 32'(done), 32'(b == N + f - 1));
`ifdef FMAP_PINGPONG_EN
    checkOutput($sformatf("%s_t%0d_bank", name, t), 32'(bank), 32'(model_stream));
`else
    if (bank !== 1'b0) checkOutput($sformatf("%s_bank", name), 32'(bank), 32'h0);
`endif
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_a_busy"}, 32'(bus_a.busy), 32'h0);
    checkOutput({tag, "_a_valid"}, 32'(bus_a.data_valid_out), 32'h0);
    checkOutput({tag, "_a_data"}, bus_a.data_out, 32'h0);
    checkOutput({tag, "_a_done"}, 32'(bus_a.frame_done), 32'h0);
    checkOutput({tag, "_b_busy"}, 32'(bus_b.busy), 32'h0);
    checkOutput({tag, "_b_valid"}, 32'(bus_b.data_valid_out), 32'h0);
    checkOutput({tag, "_b_data"}, bus_b.data_out, 32'h0);
    checkOutput({tag, "_b_done"}, 32'(bus_b.frame_done), 32'h0);
`ifdef FMAP_PINGPONG_EN
    checkOutput({tag, "_a_bank"}, 32'(bus_a.stream_bank), 32'h0);
`endif
  endtask

  function automatic logic bankA();
`ifdef FMAP_PINGPONG_EN
    return bus_a.stream_bank;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic bankB();
`ifdef FMAP_PINGPONG_EN
    return bus_b.stream_bank;
`else
    return 1'b0;
`endif
  endfunction

  // One frame from the start cycle; ends in the first idle cycle of the FLUSH_LEN=5 instance
  task automatic applyStimulus(input int reset_beat, input bit pokes, input bit wr_on_start);
    logic [31:0] d;
    start = 1'b1;
    if (wr_on_start) begin
      d = $urandom;
      wr_en = 1'b1; wr_addr = '0; wr_data = d;
      modelWrite(0, d, 1'b0);
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    modelStart();
    for (int t = 0; t <= N + F_A + 1; t++) begin
      checkDut("a", F_A, t, bus_a.busy, bus_a.data_valid_out, bus_a.data_out, bus_a.frame_done, bankA());
      checkDut("b", F_B, t, bus_b.busy, bus_b.data_valid_out, bus_b.data_out, bus_b.frame_done, bankB());
      wr_en = 1'b0; start = 1'b0;
      if (reset_beat >= 0 && t == reset_beat + 1) begin
        resetn = 1'b0;
        #1;
        checkZero($sformatf("rst_t%0d", t));
        model_stream = 0;
        tick();
        resetn = 1'b1;
        tick();
        return;
      end
      if (pokes && t >= 1 && t <= N) begin
        d = $urandom;
        wr_en = 1'b1; wr_addr = AW'(t - 1); wr_data = d;
        modelWrite(t - 1, d, 1'b1);
      end
      if (pokes && t == 5) start = 1'b1;
      if (t < N + F_A + 1) tick();
    end
    wr_en = 1'b0; start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    checkZero("reset");
    resetn = 1'b1;
    tick();
    for (int i = 0; i < N; i++) writeWord(i, toFloat(i));
    applyStimulus(-1, 1'b1, 1'b0);
    applyStimulus(-1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) writeWord(int'($urandom_range(0, N - 1)), $urandom);
    applyStimulus(-1, 1'b0, 1'b1);
    applyStimulus(7, 1'b0, 1'b0);
    applyStimulus(-1, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      int nw;
      nw = int'($urandom_range(0, 6));
      for (int i = 0; i < nw; i++) writeWord(int'($urandom_range(0, N - 1)), $urandom);
      applyStimulus(-1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
